mp_regfile: RTL and testbench

MP_REGFILE -- requirements
Module: mp_regfile

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/mp_regfile_rf_wr_merge.sv | 44 ++++
 rtl/mp_regfile.sv | 102 ++++++++++
 tb/tb_mp_regfile.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and byte-merge helper for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 64;
  localparam int RF_NRD    = 2;
  localparam int RF_NWR    = 2;
  localparam int RF_MAX_W  = 256;

  // Callers zero-extend narrower words to RF_MAX_W and slice the result.
  function automatic logic [RF_MAX_W-1:0] byte_merge(
    input logic [RF_MAX_W-1:0]   old_w,
    input logic [RF_MAX_W-1:0]   new_w,
    input logic [RF_MAX_W/8-1:0] be
  );
    logic [RF_MAX_W-1:0] m;
    m = old_w;
    for (int b = 0; b < RF_MAX_W/8; b++) begin
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mp_regfile_rf_wr_merge.sv
// Next-state of every register after applying all write ports in
// ascending port order, so the highest-index port wins each byte.
module rf_wr_merge
  import regfile_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int DEPTH     = RF_DEPTH,
  parameter int NWR       = RF_NWR,
  parameter int ZERO_REG0 = 0,
  parameter int AW        = $clog2(RF_DEPTH),
  parameter int NB        = RF_DATA_W/8
)(
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  logic [NWR-1:0]               i_we,
  input  logic [NWR*AW-1:0]            i_wa,
  input  logic [NWR*DATA_W-1:0]        i_wd,
  input  logic [NWR*NB-1:0]            i_wbe,
  output logic [DEPTH-1:0][DATA_W-1:0] o_next
);

  logic [DATA_W-1:0]   w_word;
  logic [RF_MAX_W-1:0] w_tmp;

  always_comb begin
    w_word = '0;
    w_tmp  = '0;
    o_next = i_mem;
    for (int r = 0; r < DEPTH; r++) begin
      w_word = i_mem[r];
      for (int i = 0; i < NWR; i++) begin
        if (i_we[i] && i_wa[i*AW +: AW] == AW'(r)
            && !(ZERO_REG0 != 0 && r == 0)) begin
          w_tmp = byte_merge(
            RF_MAX_W'(w_word),
            RF_MAX_W'(i_wd[i*DATA_W +: DATA_W]),
            (RF_MAX_W/8)'(i_wbe[i*NB +: NB]));
          w_word = w_tmp[DATA_W-1:0];
        end
      end
      o_next[r] = w_word;
    end
  end

endmodule

// File: rtl/mp_regfile.sv
// Flip-flop register file with NWR byte-masked write ports and NRD
// registered read ports, optional write-to-read bypass.
module mp_regfile
  import regfile_pkg::*;
#(
  parameter  int DATA_W    = RF_DATA_W,
  parameter  int DEPTH     = RF_DEPTH,
  parameter  int NRD       = RF_NRD,
  parameter  int NWR       = RF_NWR,
  parameter  int BYPASS    = 1,
  parameter  int ZERO_REG0 = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = DATA_W/8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NWR*NB-1:0]     wbe,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rvalid
);

  localparam int NA = 1 << AW;

  if (DATA_W % 8 != 0) begin : g_bad_w
    $error("mp_regfile: DATA_W must be a multiple of 8");
  end
  if (DATA_W > RF_MAX_W) begin : g_big_w
    $error("mp_regfile: DATA_W exceeds RF_MAX_W");
  end
  if (DEPTH < 2) begin : g_bad_d
    $error("mp_regfile: DEPTH must be at least 2");
  end
  if (NRD < 1 || NWR < 1) begin : g_bad_p
    $error("mp_regfile: NRD and NWR must be at least 1");
  end

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0][DATA_W-1:0] w_next;
  logic [NA-1:0][DATA_W-1:0]    w_cur;
  logic [NA-1:0][DATA_W-1:0]    w_nxt;
  logic [NRD-1:0][DATA_W-1:0]   w_rdata;
  logic [NRD*DATA_W-1:0]        r_rd;
  logic [NRD-1:0]               r_rvalid;

  rf_wr_merge #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .NWR       (NWR),
    .ZERO_REG0 (ZERO_REG0),
    .AW        (AW),
    .NB        (NB)
  ) u_merge (
    .i_mem  (r_mem),
    .i_we   (we),
    .i_wa   (wa),
    .i_wd   (wd),
    .i_wbe  (wbe),
    .o_next (w_next)
  );

  // Full address space view; holes above DEPTH read as zero.
  for (genvar k = 0; k < NA; k++) begin : g_view
    if (k < DEPTH) begin : g_in
      assign w_cur[k] = r_mem[k];
      assign w_nxt[k] = w_next[k];
    end else begin : g_out
      assign w_cur[k] = '0;
      assign w_nxt[k] = '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int j = 0; j < NRD; j++) begin
      w_rdata[j] = (BYPASS != 0) ? w_nxt[ra[j*AW +: AW]]
                                 : w_cur[ra[j*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem    <= '0;
      r_rd     <= '0;
      r_rvalid <= '0;
    end else begin
      r_mem    <= w_next;
      r_rvalid <= re;
      for (int j = 0; j < NRD; j++) begin
        if (re[j]) r_rd[j*DATA_W +: DATA_W] <= w_rdata[j];
      end
    end
  end

  assign rd     = r_rd;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_mp_regfile.sv
// Bench for mp_regfile: a bypassing 64-entry instance and a
// non-bypassing 48-entry zero-reg0 instance share the same stimulus.
module tb_mp_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [11:0] wa;
  logic [63:0] wd;
  logic [7:0]  wbe;
  logic [1:0]  re;
  logic [11:0] ra;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  rv_a, rv_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [48];
  logic [31:0] ea [2];
  logic [31:0] eb [2];
  logic [1:0]  eva, evb;

  always #5 clk = ~clk;

  mp_regfile #(
    .DATA_W(32), .DEPTH(64), .NRD(2), .NWR(2),
    .BYPASS(1), .ZERO_REG0(0)
  ) dut_a (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .re(re), .ra(ra), .rd(rd_a), .rvalid(rv_a)
  );

  mp_regfile #(
    .DATA_W(32), .DEPTH(48), .NRD(2), .NWR(2),
    .BYPASS(0), .ZERO_REG0(1)
  ) dut_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .re(re), .ra(ra), .rd(rd_b), .rvalid(rv_b)
  );

  task automatic model_reset();
    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
    ea[0] = '0; ea[1] = '0; eb[0] = '0; eb[1] = '0;
    eva = '0; evb = '0;
  endtask

  task automatic idle();
    we = '0; re = '0; wa = '0; wd = '0; wbe = '0; ra = '0;
  endtask

  task automatic set_wr(input int p, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    we[p] = 1'b1;
    wa[p*6 +: 6] = a;
    wd[p*32 +: 32] = d;
    wbe[p*4 +: 4] = be;
  endtask

  task automatic set_rd(input int p, input logic [5:0] a);
    re[p] = 1'b1;
    ra[p*6 +: 6] = a;
  endtask

  // Apply the cycle's accesses to the model, then clock the DUTs.
  task automatic tick();
    logic [31:0] na [64];
    logic [31:0] nb [48];
    int a;
    na = mem_a;
    nb = mem_b;
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        a = int'(wa[i*6 +: 6]);
        for (int b = 0; b < 4; b++) begin
          if (wbe[i*4 + b]) begin
            na[a][b*8 +: 8] = wd[i*32 + b*8 +: 8];
            if (a < 48 && a != 0) nb[a][b*8 +: 8] = wd[i*32 + b*8 +: 8];
          end
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (re[j]) begin
        a = int'(ra[j*6 +: 6]);
        ea[j] = na[a];
        eb[j] = (a < 48 && a != 0) ? mem_b[a] : 32'h0;
      end
    end
    eva = re;
    evb = re;
    @(posedge clk);
    mem_a = na;
    mem_b = nb;
    #1;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (rd_a !== '0 || rd_b !== '0) begin
      n_errors++; $display("FAIL reset_rd: got %h/%h expected 0", rd_a, rd_b);
    end
    if (rv_a !== '0) begin
      n_errors++; $display("FAIL reset_rv_a: got %b expected 00", rv_a);
    end
    if (rv_b !== '0) begin
      n_errors++; $display("FAIL reset_rv_b: got %b expected 00", rv_b);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(); set_wr(0, 6'd5, 32'hDEADBEEF, 4'hF); tick();
    idle(); set_rd(0, 6'd5); tick();
    if (rd_a[31:0] !== 32'hDEADBEEF || rv_a[0] !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset_rd: got %h/%b expected deadbeef/1", rd_a[31:0], rv_a[0]);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks += 2;
    if (rd_a !== '0 || rd_b !== '0) begin
      n_errors++; $display("FAIL async_reset_rd: got %h/%h expected 0", rd_a, rd_b);
    end
    if (rv_a !== '0 || rv_b !== '0) begin
      n_errors++; $display("FAIL async_reset_rv: got %b/%b expected 00", rv_a, rv_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(); set_rd(0, 6'd5); tick();
    n_checks++;
    if (rd_a[31:0] !== 32'h0 || rv_a[0] !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_rd: got %h/%b expected 0/1", rd_a[31:0], rv_a[0]);
    end
  endtask

  task automatic test_byte_enable();
    idle(); set_wr(0, 6'd3, 32'h11223344, 4'hF); tick();
    idle(); set_wr(1, 6'd3, 32'hAABBCCDD, 4'b0101); tick();
    idle(); set_rd(1, 6'd3); tick();
    n_checks += 2;
    if (rd_a[63:32] !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL byte_en_a: got %h expected 11bb33dd", rd_a[63:32]);
    end
    if (rd_b[63:32] !== 32'h11BB33DD) begin
      n_errors++; $display("FAIL byte_en_b: got %h expected 11bb33dd", rd_b[63:32]);
    end
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 6'd7, 32'hFFFFFFFF, 4'hF);
    set_wr(1, 6'd7, 32'h00000000, 4'b0011);
    tick();
    idle(); set_rd(0, 6'd7); tick();
    n_checks += 2;
    if (rd_a[31:0] !== 32'hFFFF0000) begin
      n_errors++; $display("FAIL conflict_a: got %h expected ffff0000", rd_a[31:0]);
    end
    if (rd_b[31:0] !== 32'hFFFF0000) begin
      n_errors++; $display("FAIL conflict_b: got %h expected ffff0000", rd_b[31:0]);
    end
  endtask

  task automatic test_bypass();
    idle(); set_wr(0, 6'd9, 32'h1, 4'hF); tick();
    idle(); set_wr(1, 6'd9, 32'h2, 4'hF);
    set_rd(0, 6'd9); set_rd(1, 6'd9); tick();
    n_checks += 3;
    if (rd_a !== {32'h2, 32'h2}) begin
      n_errors++; $display("FAIL bypass_on: got %h expected both 2", rd_a);
    end
    if (rd_b !== {32'h1, 32'h1}) begin
      n_errors++; $display("FAIL bypass_off: got %h expected both 1", rd_b);
    end
    if (rv_a !== 2'b11 || rv_b !== 2'b11) begin
      n_errors++; $display("FAIL bypass_rv: got %b/%b expected 11", rv_a, rv_b);
    end
  endtask

  task automatic test_zero_reg();
    idle(); set_wr(0, 6'd0, 32'h1234, 4'hF); set_rd(1, 6'd0); tick();
    n_checks += 2;
    if (rd_b[63:32] !== 32'h0) begin
      n_errors++; $display("FAIL zero_reg_same: got %h expected 0", rd_b[63:32]);
    end
    if (rd_a[63:32] !== 32'h1234) begin
      n_errors++; $display("FAIL reg0_normal: got %h expected 1234", rd_a[63:32]);
    end
    idle(); set_rd(0, 6'd0); tick();
    n_checks++;
    if (rd_b[31:0] !== 32'h0 || rv_b[0] !== 1'b1) begin
      n_errors++; $display("FAIL zero_reg_later: got %h/%b expected 0/1", rd_b[31:0], rv_b[0]);
    end
  endtask

  task automatic test_out_of_range();
    idle(); set_wr(1, 6'd50, 32'hCAFE0001, 4'hF); tick();
    idle(); set_rd(0, 6'd50); set_rd(1, 6'd63); tick();
    n_checks += 3;
    if (rd_b !== '0) begin
      n_errors++; $display("FAIL oob_rd: got %h expected 0", rd_b);
    end
    if (rv_b !== 2'b11) begin
      n_errors++; $display("FAIL oob_rvalid: got %b expected 11", rv_b);
    end
    if (rd_a[31:0] !== 32'hCAFE0001) begin
      n_errors++; $display("FAIL inrange_50: got %h expected cafe0001", rd_a[31:0]);
    end
  endtask

  task automatic test_hold();
    logic [63:0] prev;
    prev = rd_a;
    idle(); set_wr(0, 6'd50, 32'h5555AAAA, 4'hF); tick();
    n_checks += 2;
    if (rd_a !== prev) begin
      n_errors++; $display("FAIL hold_rd: got %h expected %h", rd_a, prev);
    end
    if (rv_a !== 2'b00 || rv_b !== 2'b00) begin
      n_errors++; $display("FAIL hold_rv: got %b/%b expected 00", rv_a, rv_b);
    end
  endtask

  function automatic logic [5:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 6'd0;
      1: return 6'd7;
      2: return 6'd50;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(p, pick_addr(), $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) != 0) set_rd(p, pick_addr());
      end
      tick();
      for (int j = 0; j < 2; j++) begin
        n_checks += 2;
        if (rd_a[j*32 +: 32] !== ea[j] || rv_a[j] !== eva[j]) begin
          n_errors++;
          $display("FAIL rand_a%0d cyc %0d: got %h/%b expected %h/%b",
                   j, n, rd_a[j*32 +: 32], rv_a[j], ea[j], eva[j]);
        end
        if (rd_b[j*32 +: 32] !== eb[j] || rv_b[j] !== evb[j]) begin
          n_errors++;
          $display("FAIL rand_b%0d cyc %0d: got %h/%b expected %h/%b",
                   j, n, rd_b[j*32 +: 32], rv_b[j], eb[j], evb[j]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    test_reset();
    test_byte_enable();
    test_conflict();
    test_bypass();
    test_zero_reg();
    test_out_of_range();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
